demux8_pipe: RTL and testbench
==============================

// Module: demux8_pipe
// PURPOSE
//  Registered 1-to-8 demultiplexer: the write-side counterpart of the 8:1 result mux.
//  Takes one 32-bit word plus a 3-bit destination select over a valid/ready handshake.
//  Delivers the word to exactly one of 8 output channels, each with its own valid/ready.
//  Contains a 2-entry skid buffer: full throughput, registered in_ready, no comb path ready->ready.
// PARAMETERS
//  DW   32  data width
//  NCH  8   output channel count (fixed at 8; select is 3 bits)
//  CW   16  per-channel transfer counter width (used only with DEMUX8_STATS_EN)
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous reset, active low
//  in_valid   in   1       upstream word valid
//  in_ready   out  1       upstream may transfer (registered)
//  in_data    in   DW      word
//  in_sel     in   3       destination channel 0..7
//  out_valid  out  NCH     one-hot channel valid; at most one bit set
//  out_ready  in   NCH     per-channel accept
//  out_data   out  DW      shared data bus, meaningful on the channel whose valid is set
//  out_cnt    out  NCH*CW  per-channel accepted-word counters (DEMUX8_STATS_EN only)
// BEHAVIOUR
//  Reset (async assert, sync deassert handled upstream): state EMPTY, out_valid=0, out_data=0,
//   in_ready=1, skid regs=0, out_cnt=0. Reset mid-transfer drops all held words.
//  In transfer: in_valid&in_ready. Out transfer: out_valid[k]&out_ready[k], k=main.sel.
//  Only out_ready[main.sel] matters; other out_ready bits are ignored.
//  States (main = output reg, skid = overflow reg):
//   EMPTY: in xfer -> load main, go BUSY. Latency in->out_valid = 1 cycle.
//   BUSY : in xfer & out xfer -> reload main, stay BUSY; in xfer only -> load skid, go FULL;
//          out xfer only -> EMPTY; neither -> hold.
//   FULL : in_ready=0; out xfer -> skid moves to main, go BUSY; else hold.
//  in_ready = (state != FULL), registered from next-state.
//  out_valid = (state!=EMPTY) ? onehot(main.sel) : 0. out_data = main.data.
//  Held main word and valid are stable until accepted (no retraction, no data change).
//  Ordering preserved across channels: strictly FIFO; a stalled channel blocks all (no bypass).
//  Sel values 0..7 all legal; no wrap or error case.
// CONFIGURATION
//  DEMUX8_STATS_EN defined: out_cnt[k*CW +: CW] increments on each out xfer to channel k,
//   wraps 2^CW-1 -> 0, cleared only by reset.
//  Undefined: out_cnt port absent-tied to 0, counter logic not elaborated; handshake identical.
// STRUCTURE
//  Shared package demux8_pkg: DW/NCH/CW constants, typedef struct {logic[2:0] sel;
//   logic[DW-1:0] data;} dmx_word_t, typedef enum logic[1:0] {EMPTY,BUSY,FULL} dmx_state_t.
//  One sub-module natural: demux8_onehot (3-bit sel -> 8-bit one-hot, combinational).
// TESTING
//  1 reset: rst_n=0 mid-FULL -> out_valid=0, in_ready=1, state EMPTY, out_cnt=0 immediately.
//  2 streaming: 8 words sel=0..7, data=0xA0..0xA7, all out_ready=1 -> one word/cycle,
//    out_valid=0x01,0x02..0x80 in order, 1-cycle latency, in_ready stays 1.
//  3 backpressure: sel=3 data=0x1234, out_ready=0 for 5 cycles, second word sel=5 0x5678
//    -> FULL, in_ready=0 next cycle, out_valid=0x08 stable, then release -> 0x1234 then 0x5678.
//  4 wrong-channel ready: main sel=2, out_ready=0xFB (bit2 low) -> no transfer, word held.
//  5 simultaneous in/out in BUSY: continuous traffic with out_ready toggling 1/0 -> no word
//    lost/duplicated, order matches scoreboard.
//  6 stats (DEMUX8_STATS_EN, CW=4): 17 words to ch6 -> out_cnt[ch6]=1 (wrapped), others 0.

Source files
------------

// File: rtl/demux8_pkg.sv
// demux8_pkg: shared constants, word/state types for the 1-to-8 demultiplexer
package demux8_pkg;
    localparam int DW  = 32;
    localparam int NCH = 8;
    localparam int CW  = 16;
    typedef struct packed {
        logic [2:0]    sel;
        logic [DW-1:0] data;
    } dmx_word_t;
    typedef enum logic [1:0] {EMPTY, BUSY, FULL} dmx_state_t;
endpackage

// File: rtl/demux8_onehot.sv
// demux8_onehot: 3-bit channel select to 8-bit one-hot decode (combinational)
//  sel    in  3    channel index 0..7
//  onehot out NCH  single bit set at position sel
module demux8_onehot
    import demux8_pkg::*;
(
    input  logic [2:0]     sel,
    output logic [NCH-1:0] onehot
);
    assign onehot = NCH'(1) << sel;
endmodule

// File: rtl/demux8_pipe.sv
// demux8_pipe: registered 1-to-8 demux with 2-entry skid buffer over valid/ready
//  clk       in   1       clock, rising edge
//  rst_n     in   1       asynchronous reset, active low
//  in_valid  in   1       upstream word valid
//  in_ready  out  1       upstream may transfer (registered)
//  in_data   in   DW      word
//  in_sel    in   3       destination channel
//  out_valid out  NCH     one-hot channel valid
//  out_ready in   NCH     per-channel accept (only the selected bit is used)
//  out_data  out  DW      shared data bus
//  out_cnt   out  NCH*CW  per-channel accepted-word counters when DEMUX8_STATS_EN
//                         is defined, otherwise tied to 0
module demux8_pipe #(
    parameter int CW = demux8_pkg::CW
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [demux8_pkg::DW-1:0]     in_data,
    input  logic [2:0]                    in_sel,
    output logic [demux8_pkg::NCH-1:0]    out_valid,
    input  logic [demux8_pkg::NCH-1:0]    out_ready,
    output logic [demux8_pkg::DW-1:0]     out_data,
    output logic [demux8_pkg::NCH*CW-1:0] out_cnt
);
    import demux8_pkg::*;
    dmx_state_t     state, state_nx;
    dmx_word_t      main_q, skid_q;
    logic [NCH-1:0] sel_oh;
    logic           in_x, out_x;
    demux8_onehot u_onehot (.sel(main_q.sel), .onehot(sel_oh));
    assign in_x      = in_valid & in_ready;
    assign out_x     = (state != EMPTY) & out_ready[main_q.sel];
    assign out_valid = (state != EMPTY) ? sel_oh : '0;
    assign out_data  = main_q.data;
    always_comb begin
        state_nx = state;
        if (state == EMPTY)
            state_nx = in_x ? BUSY : EMPTY;
        else if (state == BUSY)
            state_nx = (in_x & ~out_x) ? FULL : (~in_x & out_x) ? EMPTY : BUSY;
        else
            state_nx = out_x ? BUSY : FULL;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            state    <= state_nx;
            in_ready <= (state_nx != FULL);
            // in_x never occurs in FULL, so input loads main when it is empty or draining
            if (in_x & ((state == EMPTY) | out_x))
                main_q <= '{sel: in_sel, data: in_data};
            else if ((state == FULL) & out_x)
                main_q <= skid_q;
            if (in_x & (state == BUSY) & ~out_x)
                skid_q <= '{sel: in_sel, data: in_data};
        end
    end
`ifdef DEMUX8_STATS_EN
    logic [CW-1:0] cnt_q [NCH];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++)
                if (out_x && (main_q.sel == 3'(i))) cnt_q[i] <= cnt_q[i] + CW'(1);
        end
    end
    always_comb begin
        out_cnt = '0;
        for (int i = 0; i < NCH; i++) out_cnt[i*CW +: CW] = cnt_q[i];
    end
`else
    assign out_cnt = '0;
`endif
endmodule

// File: tb/tb_demux8_pipe.sv
// tb_demux8_pipe: directed + random check of demux8_pipe against a queue model
module tb_demux8_pipe;
`ifdef DEMUX8_STATS_EN
    localparam int TB_CW = 4;
`else
    localparam int TB_CW = 16;
`endif
    typedef struct packed {
        logic [2:0]  sel;
        logic [31:0] data;
    } w_t;
    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [31:0]          in_data = '0;
    logic [2:0]           in_sel = '0;
    logic [7:0]           out_valid;
    logic [7:0]           out_ready = '0;
    logic [31:0]          out_data;
    logic [8*TB_CW-1:0]   out_cnt;
    int n_chk = 0;
    int n_fail = 0;
    w_t q[$];
    int unsigned cnt[8];
    demux8_pipe #(.CW(TB_CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_cnt(out_cnt)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic check_all(input string tag);
        logic [7:0]         ev;
        logic [8*TB_CW-1:0] ec;
        ev = (q.size() > 0) ? (8'(1) << q[0].sel) : 8'h00;
        ec = '0;
        for (int k = 0; k < 8; k++) ec[k*TB_CW +: TB_CW] = TB_CW'(cnt[k]);
        chk({tag, ".out_valid"}, 256'(out_valid), 256'(ev));
        chk({tag, ".in_ready"}, 256'(in_ready), 256'(q.size() < 2));
        if (q.size() > 0) chk({tag, ".out_data"}, 256'(out_data), 256'(q[0].data));
        chk({tag, ".out_cnt"}, 256'(out_cnt), 256'(ec));
    endtask
    task automatic step(input string tag, input logic v, input logic [2:0] s,
                        input logic [31:0] d, input logic [7:0] r);
        logic ix, ox;
        w_t   w;
        @(negedge clk);
        in_valid = v; in_sel = s; in_data = d; out_ready = r;
        ix = v && (q.size() < 2);
        ox = (q.size() > 0) && r[q[0].sel];
        @(posedge clk);
        #1;
        if (ox) begin
`ifdef DEMUX8_STATS_EN
            cnt[q[0].sel]++;
`endif
            w = q.pop_front();
        end
        if (ix) q.push_back('{sel: s, data: d});
        check_all(tag);
    endtask
    task automatic model_reset();
        q.delete();
        for (int k = 0; k < 8; k++) cnt[k] = 0;
    endtask
    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", 256'(out_valid), 256'(0));
        chk("rst.in_ready", 256'(in_ready), 256'(1));
        chk("rst.out_data", 256'(out_data), 256'(0));
        chk("rst.out_cnt", 256'(out_cnt), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        // streaming: one word per cycle, every channel in order
        for (int i = 0; i < 8; i++) step("stream", 1'b1, 3'(i), 32'hA0 + 32'(i), 8'hFF);
        step("stream_drain", 1'b0, 3'd0, 32'h0, 8'hFF);
        // backpressure into FULL, hold, then release in order
        step("bp_a", 1'b1, 3'd3, 32'h1234, 8'h00);
        step("bp_b", 1'b1, 3'd5, 32'h5678, 8'h00);
        chk("bp.in_ready_low", 256'(in_ready), 256'(0));
        for (int i = 0; i < 3; i++) step("bp_hold", 1'b1, 3'd7, 32'hDEAD, 8'h00);
        chk("bp.out_valid_ch3", 256'(out_valid), 256'(8'h08));
        step("bp_rel1", 1'b0, 3'd0, 32'h0, 8'hFF);
        chk("bp.second_word", 256'(out_data), 256'(32'h5678));
        step("bp_rel2", 1'b0, 3'd0, 32'h0, 8'hFF);
        // ready only on channels other than the held one
        step("wrong_ld", 1'b1, 3'd2, 32'hCAFE_0002, 8'hFB);
        for (int i = 0; i < 3; i++) step("wrong_hold", 1'b0, 3'd0, 32'h0, 8'hFB);
        chk("wrong.held", 256'(out_data), 256'(32'hCAFE_0002));
        step("wrong_rel", 1'b0, 3'd0, 32'h0, 8'h04);
        // random traffic with toggling readiness
        for (int i = 0; i < 200; i++)
            step("rand", 1'($urandom_range(0, 3) != 0), 3'($urandom), $urandom,
                 (i % 2 == 0) ? 8'hFF : 8'($urandom));
        for (int i = 0; i < 4; i++) step("rand_drain", 1'b0, 3'd0, 32'h0, 8'hFF);
        // reset asserted while FULL
        step("rf_a", 1'b1, 3'd1, 32'h1111, 8'h00);
        step("rf_b", 1'b1, 3'd4, 32'h4444, 8'h00);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst.out_valid", 256'(out_valid), 256'(0));
        chk("midrst.in_ready", 256'(in_ready), 256'(1));
        chk("midrst.out_cnt", 256'(out_cnt), 256'(0));
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 1'b0, 3'd0, 32'h0, 8'hFF);
`ifdef DEMUX8_STATS_EN
        for (int i = 0; i < 17; i++) step("stats", 1'b1, 3'd6, 32'(i), 8'hFF);
        step("stats_drain", 1'b0, 3'd0, 32'h0, 8'hFF);
        chk("stats.ch6_wrapped", 256'(out_cnt[6*TB_CW +: TB_CW]), 256'(1));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
